pc_fetch_master: RTL and testbench

- Bus master for the 16-bit program-counter register slave.
- Each instruction: reads the PC over the slave's write/read-enable + 1-bit address interface, fetches the instruction from instruction memory, issues it downstream with a valid/ready handshake, then writes the next PC back to the slave.
- Sits between the PC register block, instruction memory and the decode stage.

---
 rtl/pc_pkg.sv | 22 ++
 rtl/pc_next_calc.sv | 17 +
 rtl/pc_fetch_master.sv | 167 ++++++++++++++++
 tb/tb_pc_fetch_master.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter fetch master: FSM state
// encoding, the PC register select on the slave bus, and default sizes.
package pc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_PC   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_FETCH   = 3'd3,
    ST_ISSUE   = 3'd4,
    ST_WB_PC   = 3'd5
  } state_e;

  // The PC lives at register 0 of the slave
  localparam logic PC_REG_ADDR = 1'b0;

  localparam int DEF_WIDTH          = 16;
  localparam int DEF_INSTR_WIDTH    = 16;
  localparam int DEF_PC_INCR        = 2;
  localparam int DEF_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: a pending branch target wins, otherwise the sequential
// increment, which wraps modulo 2^WIDTH.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PC_INCR = DEF_PC_INCR
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic             br_pend_i,
  input  logic [WIDTH-1:0] br_tgt_i,
  output logic [WIDTH-1:0] nxt_pc_o
);

  assign nxt_pc_o = br_pend_i ? br_tgt_i : (pc_i + WIDTH'(PC_INCR));

endmodule

// File: rtl/pc_fetch_master.sv
// Fetch master: per instruction it reads the PC from the register slave,
// fetches the word from instruction memory, issues it downstream with a
// valid/ready handshake and writes the next PC back to the slave.
// Optional IMEM ack watchdog: define PC_FETCH_TIMEOUT_EN to enable it;
// otherwise FETCH waits indefinitely and FETCH_ERR is tied low.
module pc_fetch_master
  import pc_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
  parameter int PC_INCR        = DEF_PC_INCR,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  output logic                   PC_WRITE_ENABLE,
  output logic                   PC_READ_ENABLE,
  output logic                   PC_ADDRESS,
  output logic [WIDTH-1:0]       PC_DATA_OUT,
  input  logic [WIDTH-1:0]       PC_DATA_IN,
  output logic                   IMEM_REQ,
  output logic [WIDTH-1:0]       IMEM_ADDR,
  input  logic                   IMEM_ACK,
  input  logic [INSTR_WIDTH-1:0] IMEM_RDATA,
  input  logic                   BRANCH_VALID,
  input  logic [WIDTH-1:0]       BRANCH_TARGET,
  output logic                   INSTR_VALID,
  input  logic                   INSTR_READY,
  output logic [INSTR_WIDTH-1:0] INSTR,
  output logic [WIDTH-1:0]       INSTR_PC,
  output logic                   BUSY,
  output logic                   FETCH_ERR
);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   br_pend_q, br_pend_d;
  logic [WIDTH-1:0]       br_tgt_q, br_tgt_d;
  logic                   sel_pend;
  logic [WIDTH-1:0]       sel_tgt;
  logic [WIDTH-1:0]       nxt_pc;
  logic                   to_fire;
  logic                   fetch_err;

  // A branch arriving in the write-back cycle itself is applied to that write
  assign sel_pend = br_pend_q | BRANCH_VALID;
  assign sel_tgt  = BRANCH_VALID ? BRANCH_TARGET : br_tgt_q;

  pc_next_calc #(
    .WIDTH   (WIDTH),
    .PC_INCR (PC_INCR)
  ) u_next (
    .pc_i      (pc_q),
    .br_pend_i (sel_pend),
    .br_tgt_i  (sel_tgt),
    .nxt_pc_o  (nxt_pc)
  );

`ifdef PC_FETCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;

  // Fires on the last permitted FETCH cycle when the ack still has not come
  assign to_fire   = (state_q == ST_FETCH) && !IMEM_ACK &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign fetch_err = err_q;

  // Watchdog counter restarts on every entry to FETCH; error is sticky
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == ST_FETCH) ? to_cnt_q + 1'b1 : '0;
      err_q    <= err_q | to_fire;
    end
  end
`else
  assign to_fire   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  assign FETCH_ERR  = fetch_err;
  assign PC_ADDRESS = PC_REG_ADDR;
  assign INSTR      = instr_q;
  assign INSTR_PC   = pc_q;
  assign BUSY       = (state_q != ST_IDLE);

  // State, PC, fetched word and branch latch registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
    end
  end

  // Next-state, branch capture and bus strobes
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    br_pend_d       = br_pend_q;
    br_tgt_d        = br_tgt_q;
    PC_WRITE_ENABLE = 1'b0;
    PC_READ_ENABLE  = 1'b0;
    PC_DATA_OUT     = '0;
    IMEM_REQ        = 1'b0;
    IMEM_ADDR       = '0;
    INSTR_VALID     = 1'b0;

    // Last branch wins; the instruction in flight still issues
    if ((state_q != ST_IDLE) && BRANCH_VALID) begin
      br_pend_d = 1'b1;
      br_tgt_d  = BRANCH_TARGET;
    end

    case (state_q)
      ST_IDLE: begin
        if (EN && !fetch_err) state_d = ST_RD_PC;
      end
      ST_RD_PC: begin
        PC_READ_ENABLE = 1'b1;
        state_d        = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        pc_d    = PC_DATA_IN;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        IMEM_REQ  = 1'b1;
        IMEM_ADDR = pc_q;
        if (IMEM_ACK) begin
          instr_d = IMEM_RDATA;
          state_d = ST_ISSUE;
        end else if (to_fire) begin
          br_pend_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        INSTR_VALID = 1'b1;
        if (INSTR_READY) state_d = ST_WB_PC;
      end
      ST_WB_PC: begin
        PC_WRITE_ENABLE = 1'b1;
        PC_DATA_OUT     = nxt_pc;
        br_pend_d       = 1'b0;
        state_d         = EN ? ST_RD_PC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_master.sv
// Bench for pc_fetch_master: PC register slave and instruction memory
// models, a negedge monitor that records issued instructions and PC writes,
// and per-scenario tasks comparing those records against expectations.
module tb_pc_fetch_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic        PC_WRITE_ENABLE, PC_READ_ENABLE, PC_ADDRESS;
  logic [15:0] PC_DATA_OUT;
  logic [15:0] PC_DATA_IN;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [15:0] IMEM_RDATA;
  logic        BRANCH_VALID = 1'b0;
  logic [15:0] BRANCH_TARGET = 16'h0000;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b1;
  logic [15:0] INSTR, INSTR_PC;
  logic        BUSY, FETCH_ERR;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;

  logic        ack_en = 1'b1;
  logic        preset_en = 1'b0;
  logic [15:0] preset_val = 16'h0000;
  logic [15:0] slave_pc = 16'h0000;

  logic [31:0] obs_iss[$];
  logic [15:0] obs_wr[$];
  int          obs_wr_cyc[$];
  logic [31:0] exp_iss[$];
  logic [15:0] exp_wr[$];

  pc_fetch_master dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .PC_WRITE_ENABLE(PC_WRITE_ENABLE), .PC_READ_ENABLE(PC_READ_ENABLE),
    .PC_ADDRESS(PC_ADDRESS), .PC_DATA_OUT(PC_DATA_OUT), .PC_DATA_IN(PC_DATA_IN),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK),
    .IMEM_RDATA(IMEM_RDATA), .BRANCH_VALID(BRANCH_VALID),
    .BRANCH_TARGET(BRANCH_TARGET), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .INSTR(INSTR), .INSTR_PC(INSTR_PC),
    .BUSY(BUSY), .FETCH_ERR(FETCH_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] imem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // Instruction memory: acknowledges in the same cycle as the request
  assign IMEM_ACK   = IMEM_REQ & ack_en;
  assign IMEM_RDATA = IMEM_ACK ? imem_word(IMEM_ADDR) : 16'hDEAD;

  // PC register slave: write at the strobe edge, read data one cycle later
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (preset_en) slave_pc <= preset_val;
    else if (PC_WRITE_ENABLE) slave_pc <= PC_DATA_OUT;
    if (PC_READ_ENABLE) PC_DATA_IN <= slave_pc;
  end

  initial PC_DATA_IN = 16'h0000;

  // Monitor: record handshakes and PC writes away from the active edge
  always @(negedge CLK) begin
    if (INSTR_VALID && INSTR_READY) obs_iss.push_back({INSTR_PC, INSTR});
    if (PC_WRITE_ENABLE) begin
      obs_wr.push_back(PC_DATA_OUT);
      obs_wr_cyc.push_back(cyc);
    end
    if (PC_WRITE_ENABLE && PC_READ_ENABLE) viol <= viol + 1;
  end

  task automatic wait_pos();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_obs();
    obs_iss.delete(); obs_wr.delete(); obs_wr_cyc.delete();
    exp_iss.delete(); exp_wr.delete();
  endtask

  task automatic preset_slave(input logic [15:0] v);
    preset_val = v; preset_en = 1'b1;
    wait_pos();
    preset_en = 1'b0;
  endtask

  task automatic wait_done(input int nwr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      wait_pos();
      if (obs_wr.size() >= nwr && !BUSY) begin ok = 1'b1; break; end
    end
  endtask

  // Run n instructions back to back, dropping EN once the last one has started
  task automatic run_n(input int n, output bit ok);
    EN = 1'b1;
    if (n > 1) begin
      for (int i = 0; i < 80; i++) begin
        wait_pos();
        if (obs_wr.size() >= n - 1) break;
      end
    end else begin
      wait_pos();
    end
    EN = 1'b0;
    wait_done(n, ok);
  endtask

  task automatic test_reset();
    logic [127:0] outs;
    RST = 1'b0; EN = 1'b1;
    repeat (3) wait_pos();
    outs = {PC_WRITE_ENABLE, PC_READ_ENABLE, PC_ADDRESS, PC_DATA_OUT, IMEM_REQ,
            IMEM_ADDR, INSTR_VALID, INSTR, INSTR_PC, BUSY, FETCH_ERR};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h required 0", outs); end
    EN = 1'b0; RST = 1'b1;
    repeat (4) wait_pos();
    checks++;
    if ({BUSY, PC_READ_ENABLE, IMEM_REQ} !== 3'b000) begin
      failures++; $display("FAIL idle_hold: busy/rd/req got %b required 000", {BUSY, PC_READ_ENABLE, IMEM_REQ});
    end
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] ei, oi;
    logic [15:0] ew, ow;
    clear_obs();
    ack_en = 1'b1; INSTR_READY = 1'b1;
    preset_slave(16'h0000);
    for (int k = 0; k < 3; k++) begin
      exp_iss.push_back({16'(2 * k), imem_word(16'(2 * k))});
      exp_wr.push_back(16'(2 * k + 2));
    end
    run_n(3, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL seq_done: completed %0b required 1", ok); end
    checks++;
    if (obs_wr_cyc.size() == 3 && (obs_wr_cyc[1] - obs_wr_cyc[0] != 5 || obs_wr_cyc[2] - obs_wr_cyc[1] != 5)) begin
      failures++; $display("FAIL seq_rate: gaps %0d %0d required 5 5", obs_wr_cyc[1] - obs_wr_cyc[0], obs_wr_cyc[2] - obs_wr_cyc[1]);
    end else if (obs_wr_cyc.size() != 3) begin
      failures++; $display("FAIL seq_rate: writes %0d required 3", obs_wr_cyc.size());
    end
    while (exp_iss.size() > 0) begin
      ei = exp_iss.pop_front(); checks++;
      oi = (obs_iss.size() > 0) ? obs_iss.pop_front() : 32'hXXXXXXXX;
      if (oi !== ei) begin failures++; $display("FAIL seq_issue: got %h required %h", oi, ei); end
    end
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front(); checks++;
      ow = (obs_wr.size() > 0) ? obs_wr.pop_front() : 16'hXXXX;
      if (ow !== ew) begin failures++; $display("FAIL seq_write: got %h required %h", ow, ew); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [15:0] iv, ip;
    clear_obs();
    INSTR_READY = 1'b0;
    preset_slave(16'h0010);
    EN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_pos();
      if (INSTR_VALID) break;
    end
    EN = 1'b0;
    iv = INSTR; ip = INSTR_PC;
    checks++;
    if ({ip, iv} !== {16'h0010, imem_word(16'h0010)}) begin
      failures++; $display("FAIL bp_first: got %h/%h required 0010/%h", ip, iv, imem_word(16'h0010));
    end
    for (int i = 0; i < 3; i++) begin
      wait_pos();
      checks++;
      if (INSTR_VALID !== 1'b1 || INSTR !== iv || INSTR_PC !== ip || obs_wr.size() != 0) begin
        failures++; $display("FAIL bp_hold: valid %b instr %h pc %h writes %0d required 1 %h %h 0",
                             INSTR_VALID, INSTR, INSTR_PC, obs_wr.size(), iv, ip);
      end
    end
    INSTR_READY = 1'b1;
    exp_wr.push_back(16'h0012);
    wait_done(1, ok);
    checks++;
    if (ok !== 1'b1 || obs_wr.size() != 1 || obs_wr[0] !== exp_wr[0]) begin
      failures++; $display("FAIL bp_write: got %h (n=%0d) required %h", (obs_wr.size() > 0) ? obs_wr[0] : 16'hXXXX, obs_wr.size(), exp_wr[0]);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] ow;
    clear_obs();
    preset_slave(16'hFFFE);
    exp_wr.push_back(16'h0000);
    exp_iss.push_back({16'hFFFE, imem_word(16'hFFFE)});
    run_n(1, ok);
    checks++;
    if (obs_iss.size() != 1 || obs_iss[0] !== exp_iss[0]) begin
      failures++; $display("FAIL wrap_issue: n=%0d required %h", obs_iss.size(), exp_iss[0]);
    end
    ow = (obs_wr.size() > 0) ? obs_wr[0] : 16'hXXXX;
    checks++;
    if (ok !== 1'b1 || ow !== exp_wr[0]) begin failures++; $display("FAIL wrap_write: got %h required %h", ow, exp_wr[0]); end
  endtask

  task automatic test_branch();
    bit ok;
    logic [15:0] ow;
    // Single branch during a stalled FETCH of 0004
    clear_obs();
    ack_en = 1'b0;
    preset_slave(16'h0004);
    EN = 1'b1;
    for (int i = 0; i < 20; i++) begin wait_pos(); if (IMEM_REQ) break; end
    EN = 1'b0;
    BRANCH_VALID = 1'b1; BRANCH_TARGET = 16'h0100;
    wait_pos();
    BRANCH_VALID = 1'b0; ack_en = 1'b1;
    exp_iss.push_back({16'h0004, imem_word(16'h0004)});
    exp_wr.push_back(16'h0100);
    wait_done(1, ok);
    checks++;
    if (obs_iss.size() != 1 || obs_iss[0] !== exp_iss[0]) begin
      failures++; $display("FAIL br_slot_issue: n=%0d required %h", obs_iss.size(), exp_iss[0]);
    end
    ow = (obs_wr.size() > 0) ? obs_wr[0] : 16'hXXXX;
    checks++;
    if (ok !== 1'b1 || ow !== exp_wr[0]) begin failures++; $display("FAIL br_write: got %h required %h", ow, exp_wr[0]); end
    // Next instruction comes from the branch target
    clear_obs();
    exp_wr.push_back(16'h0102);
    run_n(1, ok);
    ow = (obs_wr.size() > 0) ? obs_wr[0] : 16'hXXXX;
    checks++;
    if (obs_iss.size() != 1 || obs_iss[0][31:16] !== 16'h0100 || ow !== exp_wr[0]) begin
      failures++; $display("FAIL br_target_fetch: pc %h write %h required 0100 %h",
                           (obs_iss.size() > 0) ? obs_iss[0][31:16] : 16'hXXXX, ow, exp_wr[0]);
    end
    // Two branches before write-back: last one wins
    clear_obs();
    ack_en = 1'b0;
    preset_slave(16'h0020);
    EN = 1'b1;
    for (int i = 0; i < 20; i++) begin wait_pos(); if (IMEM_REQ) break; end
    EN = 1'b0;
    BRANCH_VALID = 1'b1; BRANCH_TARGET = 16'h0100;
    wait_pos();
    BRANCH_TARGET = 16'h0200;
    wait_pos();
    BRANCH_VALID = 1'b0; ack_en = 1'b1;
    exp_wr.push_back(16'h0200);
    wait_done(1, ok);
    ow = (obs_wr.size() > 0) ? obs_wr[0] : 16'hXXXX;
    checks++;
    if (ok !== 1'b1 || ow !== exp_wr[0]) begin failures++; $display("FAIL br_last_wins: got %h required %h", ow, exp_wr[0]); end
    // Branch in the write-back cycle itself
    clear_obs();
    preset_slave(16'h0040);
    EN = 1'b1;
    wait_pos();
    EN = 1'b0;
    for (int i = 0; i < 20; i++) begin wait_pos(); if (PC_WRITE_ENABLE) break; end
    BRANCH_VALID = 1'b1; BRANCH_TARGET = 16'h0300;
    wait_pos();
    BRANCH_VALID = 1'b0;
    exp_wr.push_back(16'h0300);
    wait_done(1, ok);
    ow = (obs_wr.size() > 0) ? obs_wr[0] : 16'hXXXX;
    checks++;
    if (ok !== 1'b1 || ow !== exp_wr[0] || slave_pc !== 16'h0300) begin
      failures++; $display("FAIL br_in_wb: write %h slave %h required %h", ow, slave_pc, exp_wr[0]);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    logic [15:0] ow;
    clear_obs();
    ack_en = 1'b0;
    preset_slave(16'h0050);
    EN = 1'b1;
    for (int i = 0; i < 20; i++) begin wait_pos(); if (IMEM_REQ) break; end
    BRANCH_VALID = 1'b1; BRANCH_TARGET = 16'h0700;
    wait_pos();
    BRANCH_VALID = 1'b0;
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({IMEM_REQ, BUSY} !== 2'b00) begin
      failures++; $display("FAIL async_reset: req/busy got %b required 00", {IMEM_REQ, BUSY});
    end
    EN = 1'b0;
    wait_pos(); wait_pos();
    RST = 1'b1; ack_en = 1'b1;
    wait_pos();
    checks++;
    if (obs_wr.size() != 0 || slave_pc !== 16'h0050) begin
      failures++; $display("FAIL reset_no_write: writes %0d slave %h required 0 0050", obs_wr.size(), slave_pc);
    end
    exp_wr.push_back(16'h0052);
    run_n(1, ok);
    ow = (obs_wr.size() > 0) ? obs_wr[0] : 16'hXXXX;
    checks++;
    if (ok !== 1'b1 || ow !== exp_wr[0]) begin failures++; $display("FAIL reset_branch_lost: got %h required %h", ow, exp_wr[0]); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    logic [15:0] ow;
    clear_obs();
    ack_en = 1'b0;
    preset_slave(16'h0060);
    EN = 1'b1;
`ifdef PC_FETCH_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      wait_pos();
      if (FETCH_ERR) break;
      if (IMEM_REQ) n++;
    end
    checks++;
    if ({FETCH_ERR, IMEM_REQ, BUSY} !== 3'b100 || n != 15) begin
      failures++; $display("FAIL timeout: err/req/busy %b fetch cycles %0d required 100 15", {FETCH_ERR, IMEM_REQ, BUSY}, n);
    end
    ack_en = 1'b1;
    repeat (5) wait_pos();
    checks++;
    if (BUSY !== 1'b0 || obs_wr.size() != 0 || FETCH_ERR !== 1'b1) begin
      failures++; $display("FAIL timeout_stuck: busy %b writes %0d err %b required 0 0 1", BUSY, obs_wr.size(), FETCH_ERR);
    end
    EN = 1'b0;
    RST = 1'b0;
    wait_pos();
    RST = 1'b1;
    wait_pos();
    checks++;
    if (FETCH_ERR !== 1'b0) begin failures++; $display("FAIL timeout_clear: err %b required 0", FETCH_ERR); end
    ok = 1'b1; ow = 16'h0000;
`else
    repeat (20) wait_pos();
    checks++;
    if ({IMEM_REQ, FETCH_ERR, BUSY} !== 3'b101) begin
      failures++; $display("FAIL no_timeout: req/err/busy %b required 101", {IMEM_REQ, FETCH_ERR, BUSY});
    end
    EN = 1'b0; ack_en = 1'b1;
    exp_wr.push_back(16'h0062);
    wait_done(1, ok);
    ow = (obs_wr.size() > 0) ? obs_wr[0] : 16'hXXXX;
    checks++;
    if (ok !== 1'b1 || ow !== exp_wr[0]) begin failures++; $display("FAIL late_ack_write: got %h required %h", ow, exp_wr[0]); end
    n = 0;
`endif
  endtask

  task automatic test_strobes();
    checks++;
    if (viol != 0) begin failures++; $display("FAIL strobe_overlap: got %0d required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_wrap();
    test_branch();
    test_mid_reset();
    test_timeout();
    test_strobes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
